// File: rtl/barcodescanner_nios_ddr2_memory_ex_pattern_ctrl_if.sv
// Avalon-style memory request/response bundle between the pattern controller
// (master) and the memory (slave).
interface barcodescanner_nios_ddr2_memory_ex_pattern_ctrl_if #(
  parameter int ADDR_W = 8
);
  // A request (write_req or read_req) transfers on a rising edge where avl_ready
  // is 1. An unaccepted request holds addr/wdata stable. Read data returns in
  // request order, one word per cycle with avl_rdata_valid=1. There is no back-pressure.
  logic              avl_ready;
  logic              avl_write_req;
  logic              avl_read_req;
  logic [ADDR_W-1:0] avl_addr;
  logic [7:0]        avl_wdata;
  logic              avl_rdata_valid;
  logic [7:0]        avl_rdata;

  modport master (
    input  avl_ready, avl_rdata_valid, avl_rdata,
    output avl_write_req, avl_read_req, avl_addr, avl_wdata
  );

  modport slave (
    output avl_ready, avl_rdata_valid, avl_rdata,
    input  avl_write_req, avl_read_req, avl_addr, avl_wdata
  );
endinterface

// File: rtl/barcodescanner_nios_ddr2_memory_ex_pattern_ctrl.sv
// Memory pattern tester: writes an LFSR sequence to num_words addresses,
// reloads the LFSR, then reads back and counts mismatching words.
module barcodescanner_nios_ddr2_memory_ex_pattern_ctrl #(
  parameter int SEED   = 32,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    num_words,
  output logic                 lfsr_enable,
  output logic                 lfsr_pause,
  output logic                 lfsr_load,
  output logic [7:0]           lfsr_ldata,
  input  logic [7:0]           lfsr_data,
  barcodescanner_nios_ddr2_memory_ex_pattern_ctrl_if.master avl,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    RELOAD = 3'd2,
    READ   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [7:0]    SEED_BYTE = 8'(SEED);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  state_t            state;
  // One bit wider than the address so a full 2^ADDR_W-1 word pass cannot wrap.
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   iss_cnt;
  logic [ADDR_W:0]   rcv_cnt;
  logic              wr_acc;
  logic              rd_acc;
  logic              rd_hit;
  logic              mismatch;
  logic [7:0]        err_next;

  assign avl.avl_write_req = (state == WRITE);
  assign avl.avl_read_req  = (state == READ) && (iss_cnt < words_q);
  assign avl.avl_addr      = (state == WRITE) ? wr_cnt[ADDR_W-1:0] :
                             (state == READ)  ? iss_cnt[ADDR_W-1:0] : '0;
  assign avl.avl_wdata     = (state == WRITE) ? lfsr_data : 8'h00;

  assign wr_acc   = avl.avl_write_req & avl.avl_ready;
  assign rd_acc   = avl.avl_read_req & avl.avl_ready;
  assign rd_hit   = (state == READ) & avl.avl_rdata_valid;
  assign mismatch = rd_hit && (avl.avl_rdata != lfsr_data);
  assign err_next = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;

  // The LFSR steps only on an accepted write or a valid read word, so the
  // read-back sequence lines up with what was written.
  assign lfsr_enable = (state == WRITE) || (state == RELOAD) || (state == READ);
  assign lfsr_load   = (state == RELOAD);
  assign lfsr_pause  = (state == WRITE) ? !wr_acc :
                       (state == READ)  ? !avl.avl_rdata_valid : 1'b0;
  assign lfsr_ldata  = SEED_BYTE;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      words_q   <= '0;
      wr_cnt    <= '0;
      iss_cnt   <= '0;
      rcv_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            words_q   <= {1'b0, num_words};
            wr_cnt    <= '0;
            iss_cnt   <= '0;
            rcv_cnt   <= '0;
            err_count <= 8'h00;
            pass      <= 1'b0;
            if (num_words == '0) begin
              state <= FINISH;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (wr_acc) begin
            wr_cnt <= wr_cnt + CNT_ONE;
            if (wr_cnt == words_q - CNT_ONE) state <= RELOAD;
          end
        end
        RELOAD: state <= READ;
        READ: begin
          if (rd_acc) iss_cnt <= iss_cnt + CNT_ONE;
          if (rd_hit) begin
            err_count <= err_next;
            rcv_cnt   <= rcv_cnt + CNT_ONE;
            // pass is resolved with the final word's compare folded in.
            if (rcv_cnt == words_q - CNT_ONE) begin
              state <= FINISH;
              done  <= 1'b1;
              pass  <= (err_next == 8'h00);
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barcodescanner_nios_ddr2_memory_ex_pattern_ctrl.sv
// Bench for the pattern controller: LFSR and memory models, write scoreboard,
// directed and randomized passes against an arithmetic reference of the sequence.
module tb_barcodescanner_nios_ddr2_memory_ex_pattern_ctrl;
  localparam int ADDR_W = 9;
  localparam int SEED   = 32;
  localparam int W      = ADDR_W + 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] num_words;
  logic              lfsr_enable, lfsr_pause, lfsr_load;
  logic [7:0]        lfsr_ldata, lfsr_data;
  logic              busy, done, pass;
  logic [7:0]        err_count;
  logic [2:0]        dbg_state;

  barcodescanner_nios_ddr2_memory_ex_pattern_ctrl_if #(.ADDR_W(ADDR_W)) avl ();

  barcodescanner_nios_ddr2_memory_ex_pattern_ctrl #(.SEED(SEED), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
    .lfsr_enable(lfsr_enable), .lfsr_pause(lfsr_pause), .lfsr_load(lfsr_load),
    .lfsr_ldata(lfsr_ldata), .lfsr_data(lfsr_data), .avl(avl),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .dbg_state(dbg_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=no summary expected=run completes");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  logic [7:0]        mem     [0:511];
  logic [7:0]        corrupt [0:511];
  int ready_pct  = 100;
  int valid_pct  = 100;
  int stall_addr = 0;
  int stall_left = 0;
  int rvalid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: k-th word of x^8+x^4+x^3+x^2+1 shift sequence from the seed byte.
  function automatic logic [7:0] ref_word(input int k);
    int v;
    v = SEED % 256;
    for (int i = 0; i < k; i++) v = ((v * 2) % 256) ^ ((v >= 128) ? 29 : 0);
    return 8'(v);
  endfunction

  // LFSR device: samples its controls before the edge, updates just after it.
  initial begin : lfsr_model
    logic en, ld, ps;
    lfsr_data = 8'(SEED);
    forever begin
      @(negedge clk);
      #2;
      en = lfsr_enable; ld = lfsr_load; ps = lfsr_pause;
      @(posedge clk);
      #1;
      if (!en)      lfsr_data = 8'(SEED);
      else if (ld)  lfsr_data = lfsr_ldata;
      else if (!ps) lfsr_data = ref_word(1) ^ ref_word(1) ^
                                8'((((int'(lfsr_data)) * 2) % 256) ^ ((lfsr_data >= 8'd128) ? 29 : 0));
    end
  end

  // Memory device plus write scoreboard and handshake checks.
  initial begin : mem_model
    logic [ADDR_W-1:0] a;
    logic [W-1:0]      e;
    bit                prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_wdata;
    prev_stall = 1'b0; prev_addr = '0; prev_wdata = 8'h00;
    avl.avl_ready = 1'b0; avl.avl_rdata_valid = 1'b0; avl.avl_rdata = 8'h00;
    forever begin
      @(negedge clk);
      avl.avl_rdata_valid = 1'b0;
      if (rd_q.size() != 0 && $urandom_range(99) < 32'(valid_pct)) begin
        a = rd_q.pop_front();
        avl.avl_rdata_valid = 1'b1;
        avl.avl_rdata = mem[a] ^ corrupt[a];
        rvalid_cnt++;
      end
      if (stall_left > 0 && avl.avl_write_req && int'(avl.avl_addr) == stall_addr) begin
        avl.avl_ready = 1'b0;
        stall_left--;
      end else begin
        avl.avl_ready = ($urandom_range(99) < 32'(ready_pct));
      end
      #1;
      if (reset_n) begin
        check("one_req", 32'(avl.avl_write_req & avl.avl_read_req), 0);
        if (!busy) check("idle_no_req", 32'({avl.avl_write_req, avl.avl_read_req}), 0);
        if (prev_stall)
          check("write_hold", 32'({avl.avl_write_req, avl.avl_addr, avl.avl_wdata}),
                32'({1'b1, prev_addr, prev_wdata}));
        if (avl.avl_write_req && !avl.avl_ready) check("stall_pause", 32'(lfsr_pause), 1);
      end
      prev_stall = reset_n && avl.avl_write_req && !avl.avl_ready;
      prev_addr  = avl.avl_addr;
      prev_wdata = avl.avl_wdata;
      if (avl.avl_write_req && avl.avl_ready) begin
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_word", 32'({avl.avl_addr, avl.avl_wdata}), 32'(e));
        end
        mem[avl.avl_addr] = avl.avl_wdata;
      end
      if (avl.avl_read_req && avl.avl_ready) rd_q.push_back(avl.avl_addr);
    end
  end

  // driver tasks
  task automatic load_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), ref_word(i)});
  endtask

  task automatic run_pass(input string tag, input int n, input int exp_err);
    int cyc;
    logic held_pass;
    load_expected(n);
    start = 1'b1;
    num_words = ADDR_W'(n);
    @(negedge clk);
    start = 1'b0;
    num_words = '0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40 * n + 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
    if (n == 0) check({tag, "_latency"}, 32'(cyc), 0);
    held_pass = pass;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    repeat (3) @(negedge clk);
    check({tag, "_pass_hold"}, 32'(pass), 32'(held_pass));
    check({tag, "_err_hold"}, 32'(err_count), 32'(exp_err));
  endtask

  task automatic clear_corrupt();
    for (int i = 0; i < 512; i++) corrupt[i] = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
    check({tag, "_reqs"}, 32'({avl.avl_write_req, avl.avl_read_req}), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err_count), 0);
    check({tag, "_lfsr_ctl"}, 32'({lfsr_enable, lfsr_load, lfsr_pause}), 0);
  endtask

  initial begin : stimulus
    int n, nbad, cyc, base;
    reset_n = 1'b0;
    start = 1'b0;
    num_words = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    clear_corrupt();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check("ldata", 32'(lfsr_ldata), 32'h20);
    reset_n = 1'b1;
    @(negedge clk);

    // basic pass: known sequence 0x20,0x40,0x80,0x1D
    run_pass("basic", 4, 0);
    check("seq0", 32'(mem[0]), 32'h20);
    check("seq1", 32'(mem[1]), 32'h40);
    check("seq2", 32'(mem[2]), 32'h80);
    check("seq3", 32'(mem[3]), 32'h1D);

    // one bad word at addr 1 (reads back 0x41)
    corrupt[1] = 8'h01;
    run_pass("bad_addr1", 4, 1);
    clear_corrupt();

    // three-cycle stall on the write to addr 2
    stall_addr = 2;
    stall_left = 3;
    run_pass("stall", 4, 0);
    check("stall_used", 32'(stall_left), 0);

    // empty pass
    run_pass("zero_words", 0, 0);

    // start while busy is ignored: a second start mid-pass must not restart
    load_expected(6);
    start = 1'b1; num_words = ADDR_W'(6);
    @(negedge clk);
    num_words = ADDR_W'(2);
    repeat (2) @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    check("busy_start_done", 32'(done), 1);
    check("busy_start_writes", 32'(exp_q.size()), 0);
    check("busy_start_pass", 32'(pass), 1);
    repeat (2) @(negedge clk);

    // reset in the middle of the read phase
    base = rvalid_cnt;
    load_expected(4);
    start = 1'b1; num_words = ADDR_W'(4);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rvalid_cnt < base + 2 && cyc < 200) begin @(negedge clk); cyc++; end
    check("midread_reached", 32'(rvalid_cnt >= base + 2), 1);
    reset_n = 1'b0;
    #1;
    check_reset_state("midread_reset");
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    while (rd_q.size() != 0 && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    check("stale_ignored_err", 32'(err_count), 0);
    check("stale_ignored_busy", 32'(busy), 0);
    run_pass("after_reset", 4, 0);

    // randomized passes with random back-pressure and read latency
    for (int t = 0; t < 5; t++) begin
      n = int'($urandom_range(1, 40));
      ready_pct = int'($urandom_range(30, 100));
      valid_pct = int'($urandom_range(30, 100));
      clear_corrupt();
      nbad = 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3) == 0) begin
          corrupt[i] = 8'($urandom_range(1, 255));
          nbad++;
        end
      end
      run_pass("random", n, (nbad > 255) ? 255 : nbad);
    end
    ready_pct = 100;
    valid_pct = 100;

    // 300 bad words saturate the error count
    for (int i = 0; i < 300; i++) corrupt[i] = 8'hFF;
    run_pass("saturate", 300, 255);
    clear_corrupt();

    // largest pass the counters must handle without wrap
    run_pass("full_range", 511, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barcodescanner_nios_ddr2_memory_ex_pattern_ctrl.md
BARCODESCANNER_NIOS_DDR2_MEMORY_EX_PATTERN_CTRL -- requirements
Module: barcodescanner_nios_ddr2_memory_ex_pattern_ctrl

Interface
REQ-001 Parameter SEED, default 32; LFSR seed, bits [7:0] used.
REQ-002 Parameter ADDR_W, default 8; width of word address and word count.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin a test pass; sampled only in IDLE.
REQ-006 num_words  in  ADDR_W  words per pass; sampled with start.
REQ-007 lfsr_enable  out  1  to LFSR enable; 0 holds LFSR at seed.
REQ-008 lfsr_pause  out  1  to LFSR pause; 1 freezes LFSR.
REQ-009 lfsr_load  out  1  to LFSR load strobe.
REQ-010 lfsr_ldata  out  8  to LFSR load value; always SEED[7:0].
REQ-011 lfsr_data  in  8  current LFSR value.
REQ-012 avl_ready  in  1  memory accepts a request this cycle.
REQ-013 avl_write_req  out  1  write request.
REQ-014 avl_read_req  out  1  read request.
REQ-015 avl_addr  out  ADDR_W  word address of request.
REQ-016 avl_wdata  out  8  write data.
REQ-017 avl_rdata_valid  in  1  read data valid.
REQ-018 avl_rdata  in  8  read data, returned in request order.
REQ-019 busy  out  1  pass in progress (state not IDLE).
REQ-020 done  out  1  one-cycle pulse at pass end.
REQ-021 pass  out  1  last pass result; 1 = zero mismatches.
REQ-022 err_count  out  8  mismatches in last/current pass.

Function
REQ-023 FSM states IDLE, WRITE, RELOAD, READ, FINISH.
REQ-024 IDLE: lfsr_enable=0; start=1 latches num_words, clears addr/counters/err_count, next state WRITE; num_words=0 goes directly to FINISH.
REQ-025 start while not IDLE is ignored.
REQ-026 WRITE: avl_write_req=1, avl_addr=write counter, avl_wdata=lfsr_data; request held stable until accepted (write_req & avl_ready).
REQ-027 WRITE: lfsr_enable=1, lfsr_load=0, lfsr_pause=!(write accepted); LFSR advances exactly once per accepted write.
REQ-028 On acceptance of write num_words-1 -> RELOAD.
REQ-029 RELOAD: one cycle, lfsr_enable=1, lfsr_load=1, no requests; next READ.
REQ-030 READ: avl_read_req=1 while issue counter < num_words; avl_addr=issue counter; counter increments on read_req & avl_ready.
REQ-031 READ: lfsr_pause=!avl_rdata_valid; each valid word compared with lfsr_data; mismatch increments err_count, saturating at 255.
REQ-032 READ -> FINISH in the cycle after the num_words-th valid word.
REQ-033 FINISH: one cycle, done=1, pass=(err_count==0); next IDLE.
REQ-034 avl_rdata_valid outside READ is ignored (no compare, no LFSR advance).
REQ-035 avl_write_req and avl_read_req never both 1; both 0 outside WRITE/READ.
REQ-036 pass and err_count hold after FINISH until next accepted start.
REQ-037 Counters are ADDR_W+1 bits wide so num_words = 2^ADDR_W-1 completes without wrap.

Reset
REQ-038 reset_n=0 at any time, including mid-pass: state IDLE, all requests 0, done=0, pass=0, err_count=0, counters 0, lfsr_enable=0, lfsr_load=0, lfsr_pause=0.
REQ-039 Outstanding read data arriving after reset is ignored; no memory-side abort is issued.

Verification
REQ-040 SEED=32, num_words=4, avl_ready=1, ideal memory -> wdata 0x20,0x40,0x80,0x1D at addr 0..3; done pulse, pass=1, err_count=0.
REQ-041 As REQ-040, memory returns 0x41 for addr 1 -> err_count=1, pass=0.
REQ-042 avl_ready low 3 cycles during write to addr 2 -> write_req/addr/wdata held at 2/0x80, LFSR paused, sequence unchanged.
REQ-043 num_words=0 -> FINISH one cycle after start, done=1, pass=1, no requests.
REQ-044 reset_n low in READ after 2 of 4 words -> IDLE next edge, outputs per REQ-038; new start runs clean pass=1.
REQ-045 Memory returns 300 bad words (num_words=300, ADDR_W=9) -> err_count saturates at 255, pass=0.
